// File: rtl/tcm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : tcm_arb_pkg
// Brief  : Memory-port structs and encodings shared by the TCM bank arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package tcm_arb_pkg;

    localparam int c_mem_aw             = 18;
    localparam int TCM_ARB_MAX_WAIT_DEF = 8;

    // Address/control phase towards a TCM bank; d and be use big-endian lanes.
    typedef struct packed {
        logic                sel;
        logic                wr;
        logic [c_mem_aw-1:0] a;
        logic [31:0]         d;
        logic [3:0]          be;
        logic                bsy;
    } MemC;

    typedef struct packed {
        logic [31:0] q;
    } MemR;

    typedef enum logic [0:0] {
        ST_CPU   = 1'b0,
        ST_FORCE = 1'b1
    } TcmArbSt;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } TcmOwn;

    localparam MemC c_memc_idle = '0;

    function automatic MemC dma_to_memc(
        input logic                wr,
        input logic [c_mem_aw-1:0] a,
        input logic [31:0]         d,
        input logic [3:0]          be
    );
        MemC m;
        m     = c_memc_idle;
        m.sel = 1'b1;
        m.wr  = wr;
        m.a   = a;
        m.d   = d;
        m.be  = be;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcm_arb.sv
`default_nettype none
// ============================================================================
// Module : tcm_arb
// Brief  : CPU-priority arbiter sharing one TCM bank port with a DMA/debug
//          master; a starvation counter forces a DMA slot after MAX_WAIT losses.
// Rev    : 1.0  initial release
// ============================================================================
module tcm_arb
    import tcm_arb_pkg::*;
#(
    parameter int MAX_WAIT = TCM_ARB_MAX_WAIT_DEF,
    parameter int AW       = c_mem_aw
) (
    input  logic          clk,
    input  logic          rst,
    input  MemC           cpu_c,
    output MemR           cpu_r,
    output logic          cpu_wait,
    input  logic          dma_req,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_a,
    input  logic [31:0]   dma_d,
    input  logic [3:0]    dma_be,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_q,
    output MemC           mem_c,
    input  MemR           mem_r
);

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);
    localparam logic [7:0] c_force_at = 8'(MAX_WAIT - 1);

    TcmArbSt    r_st;
    TcmArbSt    w_st_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;
    TcmOwn      r_dph_owner;
    TcmOwn      w_own_nxt;

    logic       w_run;
    logic       w_cpu_gnt;
    logic       w_dma_gnt;
    logic       w_cpu_wait;
    logic       w_dma_lost;
    MemC        w_mem_c;

    // Grants are masked by rst so the port goes quiet the moment reset asserts.
    assign w_run = ~rst;

    always_comb begin
        w_cpu_gnt      = 1'b0;
        w_dma_gnt      = 1'b0;
        w_cpu_wait     = 1'b0;
        w_st_nxt       = r_st;
        w_wait_cnt_nxt = 8'd0;

        case (r_st)
            ST_CPU: begin
                w_cpu_gnt = w_run & cpu_c.sel;
                w_dma_gnt = w_run & ~cpu_c.sel & dma_req;
            end
            ST_FORCE: begin
                w_dma_gnt  = w_run & dma_req;
                w_cpu_wait = w_run & cpu_c.sel;
            end
            default: ;
        endcase

        w_dma_lost = dma_req & ~w_dma_gnt;

        if (w_dma_lost) begin
            w_wait_cnt_nxt = (r_wait_cnt == c_max_wait) ? r_wait_cnt : r_wait_cnt + 8'd1;
        end

        case (r_st)
            ST_CPU: begin
                if (w_dma_lost && (r_wait_cnt == c_force_at)) begin
                    w_st_nxt = ST_FORCE;
                end
            end
            ST_FORCE: w_st_nxt = ST_CPU;
            default:  w_st_nxt = ST_CPU;
        endcase
    end

    // Writes return no data, so only read grants claim the data phase.
    always_comb begin
        w_own_nxt = OWN_NONE;
        if (w_cpu_gnt && !cpu_c.wr) begin
            w_own_nxt = OWN_CPU;
        end else if (w_dma_gnt && !dma_wr) begin
            w_own_nxt = OWN_DMA;
        end
    end

    always_comb begin
        w_mem_c = c_memc_idle;
        if (w_cpu_gnt) begin
            w_mem_c     = cpu_c;
            w_mem_c.bsy = 1'b0;
        end else if (w_dma_gnt) begin
            w_mem_c = dma_to_memc(dma_wr, c_mem_aw'(dma_a), dma_d, dma_be);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st        <= ST_CPU;
            r_wait_cnt  <= 8'd0;
            r_dph_owner <= OWN_NONE;
        end else begin
            r_st        <= w_st_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_dph_owner <= w_own_nxt;
        end
    end

    assign mem_c      = w_mem_c;
    assign cpu_wait   = w_cpu_wait;
    assign dma_gnt    = w_dma_gnt;
    assign cpu_r.q    = mem_r.q;
    assign dma_q      = mem_r.q;
    assign dma_rvalid = (r_dph_owner == OWN_DMA);

endmodule
`default_nettype wire

// File: doc/tcm_arb.md
Name: tcm_arb

Overview:
- Two-requester arbiter for one TCM bank.
- Shares the bank's single MemC/MemR port between the CPU memory-access path (memc[n] from the MA stage) and a DMA/debug master.
- CPU has priority; DMA is served in CPU idle cycles, and a starvation counter guarantees it forward progress.
- Sits between the MA stage and the TCM SRAM wrapper; one instance per TCM bank.

Parameters:
- MAX_WAIT, 8, consecutive DMA-pending cycles lost to the CPU before one forced DMA slot (1..255).
- AW, 18, TCM byte-address width (matches MemC.a).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_c  in  MemC  CPU request (sel, wr, a, d, be); bsy is ignored.
- cpu_r  out  MemR  CPU read data (q).
- cpu_wait  out  1  CPU access not performed this cycle; the MA stage must hold the request (ORed into mauo.bsy).
- dma_req  in  1  DMA request valid; held until granted.
- dma_wr  in  1  DMA write.
- dma_a  in  AW  DMA byte address.
- dma_d  in  32  DMA write data, big-endian lanes as MemC.d.
- dma_be  in  4  DMA byte enables (bit3 = byte 0).
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rvalid  out  1  dma_q valid (one cycle after a read grant).
- dma_q  out  32  DMA read data.
- mem_c  out  MemC  to the TCM bank.
- mem_r  in  MemR  from the TCM bank; q is valid one cycle after sel.

Behaviour:
- The TCM is a synchronous SRAM: the address phase is cycle N and q is valid in cycle N+1. The arbiter adds no latency on the CPU path.
- State register st ∈ {ST_CPU, ST_FORCE}. Reset value: ST_CPU, wait_cnt=0, dph_owner=OWN_NONE.
- Grant, combinational, evaluated every cycle:
  - ST_CPU, cpu_c.sel=1: CPU granted. mem_c=cpu_c, dma_gnt=0, cpu_wait=0.
  - ST_CPU, cpu_c.sel=0, dma_req=1: DMA granted. mem_c={sel=1, wr=dma_wr, a=dma_a, d=dma_d, be=dma_be}, dma_gnt=1.
  - ST_FORCE: DMA granted if dma_req=1; cpu_wait=cpu_c.sel; CPU request blocked (not forwarded to the SRAM).
  - Neither requester: mem_c all zeros (sel=0, wr=0).
- wait_cnt (8 bit):
  - Increments when dma_req & ~dma_gnt.
  - Clears on dma_gnt or ~dma_req.
  - Saturates at MAX_WAIT.
- Transitions:
  - ST_CPU→ST_FORCE when wait_cnt reaches MAX_WAIT-1 and the DMA loses again this cycle.
  - ST_FORCE→ST_CPU unconditionally after one cycle. If dma_req dropped, this is an empty slot and the CPU still waits for that one cycle.
- Data phase:
  - dph_owner is registered from the grant: OWN_CPU / OWN_DMA / OWN_NONE.
  - Writes set dph_owner=OWN_NONE.
  - cpu_r.q=mem_r.q, always passed through.
  - dma_q=mem_r.q.
  - dma_rvalid=(dph_owner==OWN_DMA).
- Simultaneous events: both requesting in ST_CPU → CPU wins and wait_cnt increments.
- A DMA request with dma_be=0 is still granted; the SRAM performs a no-op write or a read.
- Outputs at reset (asserted asynchronously): cpu_wait=0, dma_gnt=0, dma_rvalid=0, mem_c.sel=0, mem_c.wr=0.
- Reset mid-operation: a pending dma_rvalid is dropped. The DMA master must treat reset as abort.
- cpu_wait never asserts outside ST_FORCE, so there is zero CPU penalty when the DMA is idle.

Decomposition:
- cpu_pkg gains:
  - typedef enum {ST_CPU, ST_FORCE} TcmArbSt.
  - typedef enum {OWN_NONE, OWN_CPU, OWN_DMA} TcmOwn.
  - localparam TCM_ARB_MAX_WAIT_DEF=8.
- Reuse MemC/MemR from cpu_pkg unchanged.
- No sub-module; the starvation counter and FSM are small enough to stay inline.

Test Plan:
- CPU only:
  - cpu read a=0x00100, sel=1 for 4 cycles → mem_c mirrors cpu_c each cycle; cpu_wait=0; cpu_r.q equals the SRAM word at N+1.
- DMA only:
  - Write a=0x00200, d=0xDEADBEEF, be=4'b1111, then read 0x00200 → dma_gnt=1 on each request.
  - dma_rvalid=1 exactly one cycle after the read grant, with dma_q=0xDEADBEEF.
  - No dma_rvalid after the write.
- Starvation, MAX_WAIT=8:
  - cpu_c.sel=1 and dma_req=1 continuously → DMA granted on cycle 9 after request.
  - cpu_wait=1 on exactly that cycle; CPU served again the next cycle.
  - Pattern repeats every 9 cycles.
- Simultaneous at CPU idle gap:
  - CPU sel pattern 1,0,1 with dma_req=1 → DMA granted in the gap cycle.
  - wait_cnt resets to 0; no ST_FORCE entered.
- Forced slot abandoned:
  - dma_req drops in the cycle ST_FORCE is entered → mem_c.sel=0 that cycle and cpu_wait=1 once.
  - Returns to ST_CPU; no dma_rvalid.
- Async reset:
  - Assert rst mid DMA read (grant cycle) → dma_rvalid, dma_gnt and cpu_wait go 0 without a clock edge.
  - After release, the first CPU request passes with zero wait.
